mmio_timer_resp: RTL and testbench

- Memory-mapped responder on the cpu data bus (MemWrite / DataAdr / WriteData / ReadData), sitting beside dmem as a second target.
- Decodes a 16-byte register window at BASE_ADDR.
- Implements a 32-bit down-counting timer with load, auto-reload, expiry flag and interrupt output.
- Top-level muxes ReadData from this block when sel=1, otherwise from dmem.

---
 rtl/mmio_timer_resp.sv | 175 +++++++++++++++++
 tb/tb_mmio_timer_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_resp.sv
// rtl/mmio_timer_resp.sv - memory-mapped down-counting timer responder on the cpu data bus
// Optional prescaler compiled in with `define MMIO_TIMER_PRESCALE_EN (adds PRESC at offset 0x10).
module mmio_timer_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        irq
);

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_LOAD   = 3'd1;
    localparam logic [2:0] IDX_COUNT  = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
`ifdef MMIO_TIMER_PRESCALE_EN
    localparam logic [2:0] IDX_PRESC  = 3'd4;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Architectural state
    logic [2:0]       ctrl_q, ctrl_d;        // {irq_en, auto_reload, en}
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;
    logic             irq_q, irq_d;
`ifdef MMIO_TIMER_PRESCALE_EN
    logic [7:0]       presc_q, presc_d;
    logic [7:0]       pcnt_q, pcnt_d;
`endif

    logic [2:0] reg_idx;
    logic       wr_hit;
    logic       wr_ctrl, wr_load, wr_count, wr_status;
    logic       tick;
    logic       expire_set;

    logic en, auto_reload, irq_en;
    assign en          = ctrl_q[0];
    assign auto_reload = ctrl_q[1];
    assign irq_en      = ctrl_q[2];

    // Address decode: window size depends on whether PRESC exists
`ifdef MMIO_TIMER_PRESCALE_EN
    assign sel     = (DataAdr[31:5] == BASE_ADDR[31:5]);
    assign reg_idx = DataAdr[4:2];
`else
    assign sel     = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx = {1'b0, DataAdr[3:2]};
`endif

    // Byte lane bits and upper write data are never consumed
    logic unused_bits;
    assign unused_bits = ^{DataAdr[4], DataAdr[1:0], WriteData};

    assign wr_hit    = MemWrite & sel;
    assign wr_ctrl   = wr_hit & (reg_idx == IDX_CTRL);
    assign wr_load   = wr_hit & (reg_idx == IDX_LOAD);
    assign wr_count  = wr_hit & (reg_idx == IDX_COUNT);
    assign wr_status = wr_hit & (reg_idx == IDX_STATUS);

`ifdef MMIO_TIMER_PRESCALE_EN
    logic wr_presc;
    assign wr_presc = wr_hit & (reg_idx == IDX_PRESC);

    // Prescaler: counts 0..PRESC, ticks on the terminal value, cleared when idle or reprogrammed
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        tick    = 1'b0;
        if (wr_presc) begin
            presc_d = WriteData[7:0];
        end
        if (!en || wr_presc) begin
            pcnt_d = 8'd0;
        end else if (pcnt_q == presc_q) begin
            tick   = 1'b1;
            pcnt_d = 8'd0;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end
`else
    assign tick = en;
`endif

    // Register next state: CPU COUNT write beats the counter, expiry beats W1C
    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        expire_set = 1'b0;

        if (wr_ctrl) begin
            ctrl_d = WriteData[2:0];
        end
        if (wr_load) begin
            load_d = WriteData[CNT_W-1:0];
        end

        if (wr_count) begin
            count_d = WriteData[CNT_W-1:0];
        end else if (tick) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
                expire_set = 1'b1;
                count_d    = auto_reload ? load_q : CNT_ZERO;
            end else if (auto_reload) begin
                count_d = load_q;
            end
        end

        expired_d = expire_set | (expired_q & ~(wr_status & WriteData[0]));
        // irq is a registered copy of the visible flag, so it trails STATUS by one cycle
        irq_d     = expired_q & irq_en;
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= 3'd0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            irq_q     <= irq_d;
        end
    end

`ifdef MMIO_TIMER_PRESCALE_EN
    // Prescaler registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`endif

    assign irq = irq_q;

    // Zero-latency read mux; unselected or undecoded offsets return 0
    always_comb begin
        ReadData = 32'd0;
        if (sel) begin
            case (reg_idx)
                IDX_CTRL:   ReadData[2:0]       = ctrl_q;
                IDX_LOAD:   ReadData[CNT_W-1:0] = load_q;
                IDX_COUNT:  ReadData[CNT_W-1:0] = count_q;
                IDX_STATUS: ReadData[0]         = expired_q;
`ifdef MMIO_TIMER_PRESCALE_EN
                IDX_PRESC:  ReadData[7:0]       = presc_q;
`endif
                default:    ReadData            = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer_resp.sv
// tb/tb_mmio_timer_resp.sv - directed self-checking bench for mmio_timer_resp
module tb_mmio_timer_resp;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_LOAD   = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;
    localparam logic [31:0] A_PRESC  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        sel;
    logic        irq;

    int checks = 0;
    int failures = 0;

    mmio_timer_resp #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .sel(sel), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        DataAdr = a; WriteData = d; MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        DataAdr = a;
        #1;
        d = ReadData;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        #2;
        rd(A_CTRL, v);   checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", v, 32'd0); end
        rd(A_COUNT, v);  checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=%h", v, 32'd0); end
        rd(A_STATUS, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'd0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(posedge clk); #1; reset = 1'b1;
        // mid-count reset
        wr(A_LOAD, 32'd7); wr(A_COUNT, 32'd5); wr(A_CTRL, 32'd1);
        step();
        rd(A_COUNT, v); checks++; if (v !== 32'd4) begin failures++; $display("FAIL midreset_pre_count got=%h exp=%h", v, 32'd4); end
        reset = 1'b0;
        #1;
        rd(A_COUNT, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL midreset_count got=%h exp=%h", v, 32'd0); end
        rd(A_CTRL, v);  checks++; if (v !== 32'd0) begin failures++; $display("FAIL midreset_ctrl got=%h exp=%h", v, 32'd0); end
        rd(A_LOAD, v);  checks++; if (v !== 32'd0) begin failures++; $display("FAIL midreset_load got=%h exp=%h", v, 32'd0); end
        @(posedge clk); #1; reset = 1'b1;
        wr(A_COUNT, 32'd3);
        step(); step();
        rd(A_COUNT, v); checks++; if (v !== 32'd3) begin failures++; $display("FAIL postreset_hold got=%h exp=%h", v, 32'd3); end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        do_reset();
        wr(A_LOAD, 32'd3); wr(A_COUNT, 32'd3); wr(A_CTRL, 32'h5);
        rd(A_COUNT, v); checks++; if (v !== 32'd3) begin failures++; $display("FAIL os_c3 got=%h exp=%h", v, 32'd3); end
        step();
        rd(A_COUNT, v);  checks++; if (v !== 32'd2) begin failures++; $display("FAIL os_c2 got=%h exp=%h", v, 32'd2); end
        rd(A_STATUS, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL os_st0 got=%h exp=%h", v, 32'd0); end
        step();
        rd(A_COUNT, v);  checks++; if (v !== 32'd1) begin failures++; $display("FAIL os_c1 got=%h exp=%h", v, 32'd1); end
        step();
        rd(A_COUNT, v);  checks++; if (v !== 32'd0) begin failures++; $display("FAIL os_c0 got=%h exp=%h", v, 32'd0); end
        rd(A_STATUS, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL os_st1 got=%h exp=%h", v, 32'd1); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL os_irq_early got=%b exp=0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL os_irq got=%b exp=1", irq); end
        step();
        rd(A_COUNT, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL os_hold got=%h exp=%h", v, 32'd0); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        do_reset();
        wr(A_LOAD, 32'd2); wr(A_COUNT, 32'd2); wr(A_CTRL, 32'h7);
        rd(A_COUNT, v); checks++; if (v !== 32'd2) begin failures++; $display("FAIL ar_s0 got=%h exp=%h", v, 32'd2); end
        step();
        rd(A_COUNT, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL ar_s1 got=%h exp=%h", v, 32'd1); end
        step();
        rd(A_COUNT, v);  checks++; if (v !== 32'd2) begin failures++; $display("FAIL ar_s2 got=%h exp=%h", v, 32'd2); end
        rd(A_STATUS, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL ar_s2_st got=%h exp=%h", v, 32'd1); end
        step();
        rd(A_COUNT, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL ar_s3 got=%h exp=%h", v, 32'd1); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ar_s3_irq got=%b exp=1", irq); end
        // clear in the same cycle as an expiry: flag must stay set
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL coll_w1c got=%h exp=%h", v, 32'd1); end
        rd(A_COUNT, v);  checks++; if (v !== 32'd2) begin failures++; $display("FAIL ar_s4 got=%h exp=%h", v, 32'd2); end
        // clear outside an expiry cycle
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL ar_clr got=%h exp=%h", v, 32'd0); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ar_irq_lag got=%b exp=1", irq); end
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ar_irq_drop got=%b exp=0", irq); end
        rd(A_STATUS, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL ar_reexp got=%h exp=%h", v, 32'd1); end
        // write of 0 to STATUS has no effect
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd0);
        rd(A_STATUS, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL w0_status got=%h exp=%h", v, 32'd1); end
        // zero count with auto_reload reloads without expiry; LOAD write is deferred
        do_reset();
        wr(A_LOAD, 32'd4); wr(A_CTRL, 32'h3);
        step();
        rd(A_COUNT, v);  checks++; if (v !== 32'd4) begin failures++; $display("FAIL zero_reload got=%h exp=%h", v, 32'd4); end
        rd(A_STATUS, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL zero_noexp got=%h exp=%h", v, 32'd0); end
        wr(A_LOAD, 32'd9);
        rd(A_COUNT, v);  checks++; if (v !== 32'd3) begin failures++; $display("FAIL load_defer got=%h exp=%h", v, 32'd3); end
    endtask

    task automatic test_collision_count();
        logic [31:0] v;
        do_reset();
        wr(A_COUNT, 32'd5); wr(A_CTRL, 32'd1);
        wr(A_COUNT, 32'd10);
        rd(A_COUNT, v); checks++; if (v !== 32'd10) begin failures++; $display("FAIL coll_count got=%h exp=%h", v, 32'd10); end
        step();
        rd(A_COUNT, v); checks++; if (v !== 32'd9) begin failures++; $display("FAIL coll_next got=%h exp=%h", v, 32'd9); end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        do_reset();
        wr(A_LOAD, 32'h1234_5678);
        DataAdr = BASE + 32'h20; WriteData = 32'hFFFF_FFFF; MemWrite = 1'b1;
        #1;
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL dec_sel20 got=%b exp=0", sel); end
        checks++; if (ReadData !== 32'd0) begin failures++; $display("FAIL dec_rd20 got=%h exp=%h", ReadData, 32'd0); end
        @(posedge clk); #1;
        DataAdr = BASE - 32'h4;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        rd(A_CTRL, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL dec_ctrl got=%h exp=%h", v, 32'd0); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL dec_sel_in got=%b exp=1", sel); end
        rd(BASE + 32'h6, v); checks++; if (v !== 32'h1234_5678) begin failures++; $display("FAIL dec_load_b6 got=%h exp=%h", v, 32'h1234_5678); end
        wr(A_CTRL, 32'hFFFF_FFF8);
        rd(A_CTRL, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL ctrl_rsvd got=%h exp=%h", v, 32'd0); end
`ifndef MMIO_TIMER_PRESCALE_EN
        DataAdr = A_PRESC;
        #1;
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL dec_sel10 got=%b exp=0", sel); end
`endif
    endtask

`ifdef MMIO_TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] v;
        do_reset();
        wr(A_PRESC, 32'd3); wr(A_COUNT, 32'd2); wr(A_CTRL, 32'd1);
        rd(A_PRESC, v); checks++; if (v !== 32'd3) begin failures++; $display("FAIL presc_rd got=%h exp=%h", v, 32'd3); end
        for (int i = 1; i <= 8; i++) begin
            step();
            rd(A_COUNT, v);
            if (i == 3) begin checks++; if (v !== 32'd2) begin failures++; $display("FAIL presc_c3 got=%h exp=%h", v, 32'd2); end end
            if (i == 4) begin checks++; if (v !== 32'd1) begin failures++; $display("FAIL presc_c4 got=%h exp=%h", v, 32'd1); end end
            if (i == 7) begin
                rd(A_STATUS, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL presc_st7 got=%h exp=%h", v, 32'd0); end
            end
            if (i == 8) begin
                checks++; if (v !== 32'd0) begin failures++; $display("FAIL presc_c8 got=%h exp=%h", v, 32'd0); end
                rd(A_STATUS, v); checks++; if (v !== 32'd1) begin failures++; $display("FAIL presc_st8 got=%h exp=%h", v, 32'd1); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_collision_count();
        test_decode();
`ifdef MMIO_TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
